// File: rtl/game_ctrl_fsm.sv
// Round flow controller for Donkey-vs-Kong: start gating, lives/HUD tracking,
// post-hit invulnerability, pause, optional round timer and win/restart handling.
module game_ctrl_fsm #(
    parameter int MAX_LIVES     = 3,
    parameter int N_HAZARDS     = 10,
    parameter int IFRAME_CYCLES = 32,
    parameter int ROUND_CYCLES  = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start_game,
    input  logic                             start_game_uart,
    input  logic                             animation,
    input  logic                             pause_req,
    input  logic                             restart_req,
    input  logic                             touch_lady,
    input  logic                             is_shielded,
    input  logic [N_HAZARDS-1:0]             hazard_hit,
    output logic                             game_en,
    output logic                             paused,
    output logic                             donkey_hit,
    output logic                             invuln,
    output logic [MAX_LIVES-1:0]             health_en,
    output logic [$clog2(MAX_LIVES+1)-1:0]   lives_left,
    output logic                             donkey_win,
    output logic                             kong_win
);

    localparam int LIVES_W = $clog2(MAX_LIVES + 1);
    localparam int IF_W    = (IFRAME_CYCLES > 0) ? $clog2(IFRAME_CYCLES + 1) : 1;
    localparam int TMR_W   = (ROUND_CYCLES > 1) ? $clog2(ROUND_CYCLES) : 1;

    localparam logic [LIVES_W-1:0]   LIVES_FULL  = LIVES_W'(MAX_LIVES);
    localparam logic [LIVES_W-1:0]   LIVES_ONE   = LIVES_W'(1);
    localparam logic [LIVES_W-1:0]   LIVES_ZERO  = LIVES_W'(0);
    localparam logic [MAX_LIVES-1:0] HEALTH_FULL = {MAX_LIVES{1'b1}};
    localparam logic [IF_W-1:0]      IF_LOAD     = IF_W'(IFRAME_CYCLES);
    localparam logic [IF_W-1:0]      IF_ONE      = IF_W'(1);
    localparam logic [IF_W-1:0]      IF_ZERO     = IF_W'(0);
    localparam logic [TMR_W-1:0]     TMR_LAST    = TMR_W'((ROUND_CYCLES > 0) ? ROUND_CYCLES - 1 : 0);
    localparam logic [TMR_W-1:0]     TMR_ONE     = TMR_W'(1);
    localparam logic [TMR_W-1:0]     TMR_ZERO    = TMR_W'(0);
    localparam bit                   TMR_ON      = (ROUND_CYCLES > 0);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PLAY       = 3'd1,
        ST_PAUSE      = 3'd2,
        ST_DONKEY_WIN = 3'd3,
        ST_KONG_WIN   = 3'd4
    } state_t;

    state_t               state_r;
    state_t               state_nxt_s;
    logic [IF_W-1:0]      ifr_cnt_r;
    logic [IF_W-1:0]      ifr_nxt_s;
    logic [TMR_W-1:0]     tmr_r;
    logic [TMR_W-1:0]     tmr_nxt_s;
    logic [LIVES_W-1:0]   lives_nxt_s;
    logic [MAX_LIVES-1:0] health_nxt_s;
    logic                 hit_s;
    logic                 hit_taken_s;
    logic                 expired_s;

    // Next-state, life bookkeeping and timer updates
    always_comb begin
        state_nxt_s  = state_r;
        ifr_nxt_s    = ifr_cnt_r;
        tmr_nxt_s    = tmr_r;
        lives_nxt_s  = lives_left;
        health_nxt_s = health_en;
        hit_s        = |hazard_hit;
        hit_taken_s  = 1'b0;
        expired_s    = 1'b0;

        case (state_r)
            ST_IDLE: begin
                ifr_nxt_s    = IF_ZERO;
                tmr_nxt_s    = TMR_ZERO;
                lives_nxt_s  = LIVES_FULL;
                health_nxt_s = HEALTH_FULL;
                if (start_game && start_game_uart && !animation) begin
                    state_nxt_s = ST_PLAY;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                expired_s = TMR_ON && (tmr_r == TMR_LAST);
                if (TMR_ON && !expired_s) begin
                    tmr_nxt_s = tmr_r + TMR_ONE;
                end else begin
                    tmr_nxt_s = tmr_r;
                end
                if (ifr_cnt_r != IF_ZERO) begin
                    ifr_nxt_s = ifr_cnt_r - IF_ONE;
                end else begin
                    ifr_nxt_s = IF_ZERO;
                end
                // Reaching the lady outranks any hit in the same cycle: no life is lost
                if (touch_lady) begin
                    state_nxt_s = ST_DONKEY_WIN;
                end else begin
                    if (hit_s && !is_shielded && (ifr_cnt_r == IF_ZERO) && (lives_left != LIVES_ZERO)) begin
                        hit_taken_s  = 1'b1;
                        lives_nxt_s  = lives_left - LIVES_ONE;
                        health_nxt_s = health_en >> 1;
                        ifr_nxt_s    = IF_LOAD;
                    end else begin
                        hit_taken_s  = 1'b0;
                    end
                    if (hit_taken_s && (lives_left == LIVES_ONE)) begin
                        state_nxt_s = ST_KONG_WIN;
                    end else if (expired_s) begin
                        state_nxt_s = ST_KONG_WIN;
                    end else if (pause_req) begin
                        state_nxt_s = ST_PAUSE;
                    end else begin
                        state_nxt_s = ST_PLAY;
                    end
                end
            end
            ST_PAUSE: begin
                if (pause_req) begin
                    state_nxt_s = ST_PLAY;
                end else begin
                    state_nxt_s = ST_PAUSE;
                end
            end
            ST_DONKEY_WIN, ST_KONG_WIN: begin
                if (ifr_cnt_r != IF_ZERO) begin
                    ifr_nxt_s = ifr_cnt_r - IF_ONE;
                end else begin
                    ifr_nxt_s = IF_ZERO;
                end
                if (restart_req) begin
                    state_nxt_s  = ST_IDLE;
                    ifr_nxt_s    = IF_ZERO;
                    tmr_nxt_s    = TMR_ZERO;
                    lives_nxt_s  = LIVES_FULL;
                    health_nxt_s = HEALTH_FULL;
                end else begin
                    state_nxt_s  = state_r;
                end
            end
            default: begin
                state_nxt_s  = ST_IDLE;
                ifr_nxt_s    = IF_ZERO;
                tmr_nxt_s    = TMR_ZERO;
                lives_nxt_s  = LIVES_FULL;
                health_nxt_s = HEALTH_FULL;
            end
        endcase
    end

    // State, counters and registered outputs; flags follow the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ifr_cnt_r  <= IF_ZERO;
            tmr_r      <= TMR_ZERO;
            game_en    <= 1'b0;
            paused     <= 1'b0;
            donkey_hit <= 1'b0;
            invuln     <= 1'b0;
            health_en  <= HEALTH_FULL;
            lives_left <= LIVES_FULL;
            donkey_win <= 1'b0;
            kong_win   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            ifr_cnt_r  <= ifr_nxt_s;
            tmr_r      <= tmr_nxt_s;
            game_en    <= (state_nxt_s == ST_PLAY) || (state_nxt_s == ST_DONKEY_WIN) ||
                          (state_nxt_s == ST_KONG_WIN);
            paused     <= (state_nxt_s == ST_PAUSE);
            donkey_hit <= hit_taken_s;
            invuln     <= (ifr_nxt_s != IF_ZERO);
            health_en  <= health_nxt_s;
            lives_left <= lives_nxt_s;
            donkey_win <= (state_nxt_s == ST_DONKEY_WIN);
            kong_win   <= (state_nxt_s == ST_KONG_WIN);
        end
    end

endmodule

// File: doc/game_ctrl_fsm.md
Name: game_ctrl_fsm

Overview:
- Parametrised game-flow controller for the two-player Donkey-vs-Kong round.
- Gates game start on both players being ready, tracks Donkey's lives across N hazard channels, and applies a post-hit invulnerability window.
- Supports pause/resume, an optional round time limit, and restart from the end screens.
- Sits between the input/UART ready logic and the sprite, draw and HUD blocks.

Parameters:
- MAX_LIVES, 3, starting life count; 1..8.
- N_HAZARDS, 10, number of hazard (barrel) hit channels.
- IFRAME_CYCLES, 32, cycles of invulnerability after a registered hit; 0 disables the window.
- ROUND_CYCLES, 0, round time limit in clk cycles; 0 means no limit.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start_game  in  1  local player ready (level)
- start_game_uart  in  1  remote player ready (level)
- animation  in  1  intro animation running; start is blocked while high
- pause_req  in  1  single-cycle pulse; toggles pause
- restart_req  in  1  single-cycle pulse; leaves a win state
- touch_lady  in  1  Donkey reached the goal
- is_shielded  in  1  shield power-up active
- hazard_hit  in  N_HAZARDS  per-channel hit flags
- game_en  out  1  game logic enable
- paused  out  1  high in ST_PAUSE
- donkey_hit  out  1  one-cycle pulse per life lost
- invuln  out  1  invulnerability window active
- health_en  out  MAX_LIVES  thermometer code of remaining lives; bit i = life i shown
- lives_left  out  $clog2(MAX_LIVES+1)  remaining life count
- donkey_win  out  1  high in ST_DONKEY_WIN
- kong_win  out  1  high in ST_KONG_WIN

Behaviour:
- All outputs are registered; each output reflects the state and inputs of the previous cycle.
- Reset values: state ST_IDLE, every 1-bit output 0, health_en all ones, lives_left = MAX_LIVES, internal timers 0.
- Reset asserted mid-game returns to ST_IDLE with these values on the next edge.

States and transitions:
- ST_IDLE:
  - Holds health_en all ones and lives_left = MAX_LIVES.
  - Moves to ST_PLAY when start_game && start_game_uart && !animation.
  - game_en goes high on the same edge as that transition.
- ST_PLAY, evaluated in priority order:
  1. touch_lady → ST_DONKEY_WIN.
  2. Lethal hit → ST_KONG_WIN.
  3. Round timer expiry → ST_KONG_WIN.
  4. pause_req → ST_PAUSE.
- ST_PAUSE:
  - game_en = 0, paused = 1.
  - The round timer and invulnerability counter freeze.
  - hazard_hit and touch_lady are ignored.
  - pause_req returns to ST_PLAY, and game_en goes back to 1.
- ST_DONKEY_WIN / ST_KONG_WIN:
  - Latched. game_en stays 1, and health_en/lives_left are frozen.
  - restart_req → ST_IDLE: game_en = 0, lives restored, both win flags cleared.
- Illegal state encoding → ST_IDLE.

Hit rule (ST_PLAY only):
- hit = |hazard_hit. Any number of simultaneous channel hits in one cycle costs exactly one life.
- A hit is taken when hit && !is_shielded && !invuln. Otherwise it is ignored and donkey_hit = 0.
- On a taken hit:
  - lives_left decrements.
  - health_en shifts right by one with 0 fill; the highest set bit clears.
  - donkey_hit pulses for 1 cycle.
  - The invulnerability counter loads IFRAME_CYCLES, and invuln = 1 while the counter is non-zero.
- A hit is lethal when lives_left == 1 at the moment it is taken. That results in lives_left = 0, health_en = 0 and a transition to ST_KONG_WIN.
- lives_left never underflows.

Round timer:
- Counts cycles in ST_PLAY only and clears in ST_IDLE.
- Expiry means the count reaches ROUND_CYCLES-1.
- Logic is absent or inert when ROUND_CYCLES == 0.

Simultaneous events:
- touch_lady and a lethal hit in the same cycle → ST_DONKEY_WIN. The life is not deducted and donkey_hit = 0.
- pause_req together with any win condition → the win takes priority.
- restart_req outside the win states is ignored.
- pause_req outside ST_PLAY/ST_PAUSE is ignored.

Test Plan:
- Ready gating: assert start_game=1 and start_game_uart=1 with animation=1 for 10 cycles, then drop animation → stays in ST_IDLE with game_en=0 until the drop; next edge state=ST_PLAY, game_en=1, health_en=3'b111.
- Multi-channel hit, MAX_LIVES=3, IFRAME_CYCLES=32: hazard_hit=10'b0000010010 for 1 cycle → one donkey_hit pulse, lives_left=2, health_en=3'b011, invuln=1 for 32 cycles. Hits inside the window → no change.
- Shield and lethal hit: a hit with is_shielded=1 → no change. Three unshielded hits spaced more than 32 cycles apart → third gives health_en=0, lives_left=0, kong_win=1, state frozen afterwards.
- Priority: touch_lady=1 and a hit at lives_left=1 in the same cycle → donkey_win=1, lives_left=1, donkey_hit=0.
- Pause: pause_req during ST_PLAY with invuln counter at 20 → paused=1, game_en=0, counter holds at 20, hits ignored. Second pause_req → resumes; invuln ends after 20 more cycles.
- Timer and restart, ROUND_CYCLES=100: no events for 100 ST_PLAY cycles → kong_win=1. Then restart_req → ST_IDLE, game_en=0, lives_left=3, health_en=3'b111. rst asserted mid-ST_PLAY → same reset values next edge.
